fwd_operand_stage: RTL
======================

Name: fwd_operand_stage

Overview:
Parametrised successor to the first/second/third ALU source muxes. It selects the ALU A and B operands from NUM_SRC forwarding sources, plus an immediate for B. It registers both operands as the ID/EX operand latch, with stall hold and flush-to-bubble. Per-source saturating forwarding counters and a sticky illegal-select flag support pipeline debug and performance analysis.

Parameters:
WIDTH, 32, operand/data width in bits
NUM_SRC, 3, number of operand sources; source 0 = register file, 1 = EX forward, 2 = MEM forward, 3+ = further stages
SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_SRC
CNT_W, 16, width of each per-source forwarding counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction this cycle
stall  input  1  hold the EX operand latch
flush  input  1  squash: load a bubble into the EX operand latch
sel_a  input  SEL_W  source select for operand A (replaces Ctrl_FwdA)
sel_b  input  SEL_W  source select for operand B (replaces Ctrl_FwdB)
alu_src  input  1  1 = operand B takes imm; 0 = operand B takes the sel_b source
imm  input  WIDTH  sign-extended immediate
src_data  input  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
cnt_clr  input  1  synchronous clear of counters and error flag
ex_valid  output  1  EX operand latch holds a valid instruction
ex_op_a  output  WIDTH  registered operand A
ex_op_b  output  WIDTH  registered operand B
sel_err  output  1  sticky flag: an illegal select was used
fwd_cnt  output  NUM_SRC*CNT_W  packed per-source use counters; counter k occupies bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n=0, asynchronous): ex_valid=0, ex_op_a=0, ex_op_b=0, sel_err=0, all fwd_cnt=0. Reset mid-stall or mid-count discards all state immediately.
- Combinational select:
  - mux_a = src_data[sel_a].
  - mux_b = alu_src ? imm : src_data[sel_b].
  - Any select >= NUM_SRC yields source 0 (the register file).
- Latency: exactly 1 cycle from inputs to ex_op_a/ex_op_b/ex_valid. No combinational path from inputs to outputs.
- Latch update priority per rising edge: flush > stall > load.
  - flush=1: ex_valid<=0, ex_op_a<=0, ex_op_b<=0. This applies even when stall=1 in the same cycle.
  - stall=1, flush=0: all three registers hold.
  - Otherwise, id_valid=1: ex_valid<=1, ex_op_a<=mux_a, ex_op_b<=mux_b.
  - Otherwise, id_valid=0: bubble, same as flush.
- Capture event = id_valid & !stall & !flush. Counters and sel_err update only on capture events.
- Counters:
  - On a capture event, fwd_cnt[sel_a] increments by 1.
  - fwd_cnt[sel_b] increments by 1 only when alu_src=0.
  - If both index the same source, that counter increments by 2 in one cycle.
  - An illegal select counts against source 0.
  - Counters saturate at 2^CNT_W-1, never wrap; an increment of 2 from max-1 lands on max.
- sel_err:
  - Set on a capture event when sel_a >= NUM_SRC, or when alu_src=0 and sel_b >= NUM_SRC.
  - sel_b is ignored when alu_src=1.
  - Stays set until reset or cnt_clr.
- cnt_clr: synchronous. Zeroes all counters and sel_err. Wins over a same-cycle increment or set (that cycle's event is discarded). Does not affect the operand latch.
- Selects are don't-care while stall or flush is high.

Test Plan:
1. Reset: rst_n=0 mid-run with ex_op_a=0xDEADBEEF -> all outputs 0 immediately, without waiting for a clock edge.
2. Forward sweep: src={0x11111111,0x22222222,0x33333333}, id_valid=1, sel_a=0,1,2 on successive cycles, alu_src=0, sel_b=2,1,0 -> one cycle later ex_op_a=0x11111111/0x22222222/0x33333333 and ex_op_b reversed; fwd_cnt={2,2,2}.
3. Immediate and stall: alu_src=1, imm=0xFFFFFFF0, capture, then stall=1 for 3 cycles while src and imm change -> ex_op_b holds 0xFFFFFFF0, ex_valid holds 1, counters unchanged during the stall.
4. Flush beats stall: stall=1 and flush=1 together -> next cycle ex_valid=0, ex_op_a=ex_op_b=0; id_valid=0 with no stall gives the same bubble.
5. Illegal select: NUM_SRC=3, sel_a=3, capture -> ex_op_a=src0, sel_err=1, fwd_cnt[0]+=1. Then sel_b=3 with alu_src=1 after cnt_clr -> sel_err stays 0.
6. Saturation/clear: CNT_W=4, preload fwd_cnt[1]=14, capture with sel_a=sel_b=1, alu_src=0 -> 15; another capture -> 15. cnt_clr together with a capture -> 0.

Source files
------------

// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage: ALU operand select and ID/EX operand latch.
// Operand A comes from one of NUM_SRC forwarding sources. Operand B comes from
// one of those sources or from the immediate. Both operands are registered,
// with stall hold and flush-to-bubble. Saturating per-source use counters and
// a sticky illegal-select flag are kept for debug and performance analysis.
module fwd_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [SEL_W-1:0]         sel_a,
  input  logic [SEL_W-1:0]         sel_b,
  input  logic                     alu_src,
  input  logic [WIDTH-1:0]         imm,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     cnt_clr,
  output logic                     ex_valid,
  output logic [WIDTH-1:0]         ex_op_a,
  output logic [WIDTH-1:0]         ex_op_b,
  output logic                     sel_err,
  output logic [NUM_SRC*CNT_W-1:0] fwd_cnt
);

  // One extra bit so NUM_SRC == 2^SEL_W is still representable.
  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Unpacked view of the packed source bus.
  logic [WIDTH-1:0] src_arr [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Illegal selects fall back to source 0 and are reported through sel_err.
  logic err_a;
  logic err_b;
  logic capture;

  assign err_a   = ({1'b0, sel_a} >= NUM_SRC_L);
  assign err_b   = ({1'b0, sel_b} >= NUM_SRC_L) && !alu_src;
  assign capture = id_valid && !stall && !flush;

  // Source muxes. Source 0 is the default, so illegal selects read the
  // register file without any separate handling.
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] mux_b;

  always_comb begin
    mux_a = src_arr[0];
    src_b = src_arr[0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (sel_a == SEL_W'(k)) mux_a = src_arr[k];
      if (sel_b == SEL_W'(k)) src_b = src_arr[k];
    end
    mux_b = alu_src ? imm : src_b;
  end

  // ID/EX operand latch: flush beats stall, and stall beats load. An idle ID
  // stage loads a bubble.
  logic             ex_valid_reg;
  logic [WIDTH-1:0] ex_op_a_reg;
  logic [WIDTH-1:0] ex_op_b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg <= 1'b0;
      ex_op_a_reg  <= '0;
      ex_op_b_reg  <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid_reg <= 1'b0;
      ex_op_a_reg  <= '0;
      ex_op_b_reg  <= '0;
    end else if (!stall) begin
      ex_valid_reg <= 1'b1;
      ex_op_a_reg  <= mux_a;
      ex_op_b_reg  <= mux_b;
    end
  end

  assign ex_valid = ex_valid_reg;
  assign ex_op_a  = ex_op_a_reg;
  assign ex_op_b  = ex_op_b_reg;

  // Sticky illegal-select flag. A clear in the same cycle wins over a set.
  logic sel_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if (cnt_clr) begin
      sel_err_reg <= 1'b0;
    end else if (capture && (err_a || err_b)) begin
      sel_err_reg <= 1'b1;
    end
  end

  assign sel_err = sel_err_reg;

  // Per-source saturating counters. Each capture adds 0, 1 or 2 to a counter,
  // because A and B may both hit the same source in one cycle.
  logic [CNT_W-1:0] cnt_reg  [NUM_SRC];
  logic [CNT_W-1:0] cnt_next [NUM_SRC];

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
      logic         hit_a;
      logic         hit_b;
      logic [1:0]   inc;
      logic [CNT_W:0] sum;

      if (gi == 0) begin : g_src0
        assign hit_a = (sel_a == '0) || err_a;
        assign hit_b = !alu_src && ((sel_b == '0) || err_b);
      end else begin : g_srcn
        assign hit_a = (sel_a == SEL_W'(gi));
        assign hit_b = !alu_src && (sel_b == SEL_W'(gi));
      end

      assign inc = {1'b0, hit_a} + {1'b0, hit_b};
      assign sum = {1'b0, cnt_reg[gi]} + (CNT_W+1)'(inc);
      // The carry out means the counter went past its maximum, so hold it there.
      assign cnt_next[gi] = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];

      // Counter register: cleared synchronously, advanced only on capture.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_clr) begin
          cnt_reg[gi] <= '0;
        end else if (capture) begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end

      assign fwd_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate

endmodule
